// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_pkg : opcode constants, widths and state type for the ALU arbiter    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package alu_pkg;

    localparam int OPW           = 3;
    localparam int DEFAULT_WIDTH = 32;

    localparam logic [OPW-1:0] OP_ADD = 3'b000;
    localparam logic [OPW-1:0] OP_SUB = 3'b001;
    localparam logic [OPW-1:0] OP_AND = 3'b010;
    localparam logic [OPW-1:0] OP_OR  = 3'b011;
    localparam logic [OPW-1:0] OP_SLT = 3'b100;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_t;

    function automatic logic op_is_legal(input logic [OPW-1:0] op);
        return (op <= OP_SLT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_unit : combinational ALU (ADD/SUB/AND/OR/signed SLT), zero flag      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int OPW   = alu_pkg::OPW
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPW-1:0]   alu_opcode,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    // Unassigned opcodes produce a zero result rather than X.
    always_comb begin
        result = '0;
        case (alu_opcode)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_arbiter : two-port valid/ready arbiter sharing one alu_unit, with a  |
// | one-entry registered response. Optional macro: ALU_ARB_PERF_EN           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int OPW        = alu_pkg::OPW,
    parameter int FIXED_PRIO = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_illegal
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [31:0]      perf_grant0,
    output logic [31:0]      perf_grant1,
    output logic [31:0]      perf_stall
`endif
);

    rsp_state_t       state, state_next;
    logic             last_grant;
    logic             grant;
    logic             can_accept;
    logic             accept;
    logic [WIDTH-1:0] alu_a, alu_b, alu_result;
    logic [OPW-1:0]   alu_op;
    logic             alu_zero;

    // grant selects port 1 when high; contention resolves away from last_grant.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign can_accept = (state == ST_EMPTY) || rsp_ready;
    assign req0_ready = can_accept && req0_valid && !grant;
    assign req1_ready = can_accept && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;

    assign alu_a  = grant ? req1_a  : req0_a;
    assign alu_b  = grant ? req1_b  : req0_b;
    assign alu_op = grant ? req1_op : req0_op;

    alu_unit #(
        .WIDTH (WIDTH),
        .OPW   (OPW)
    ) u_alu (
        .a          (alu_a),
        .b          (alu_b),
        .alu_opcode (alu_op),
        .result     (alu_result),
        .zero       (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: if (accept) state_next = ST_FULL;
            ST_FULL:  if (rsp_ready && !accept) state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
    end

    assign rsp_valid = (state == ST_FULL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id      <= 1'b0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
            last_grant  <= 1'b1;
        end else if (accept) begin
            rsp_id      <= grant;
            rsp_result  <= alu_result;
            rsp_zero    <= alu_zero;
            rsp_illegal <= !op_is_legal(alu_op);
            last_grant  <= grant;
        end
    end

`ifdef ALU_ARB_PERF_EN
    logic stall;
    assign stall = (req0_valid && !req0_ready) || (req1_valid && !req1_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_grant0 <= '0;
            perf_grant1 <= '0;
            perf_stall  <= '0;
        end else begin
            if (req0_ready && (perf_grant0 != 32'hFFFF_FFFF)) perf_grant0 <= perf_grant0 + 32'd1;
            if (req1_ready && (perf_grant1 != 32'hFFFF_FFFF)) perf_grant1 <= perf_grant1 + 32'd1;
            if (stall && (perf_stall != 32'hFFFF_FFFF))       perf_stall  <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_arbiter : scoreboard bench for alu_arbiter                        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_alu_arbiter;

    localparam int FIXED_PRIO = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_illegal;
    logic [31:0] rsp_result;
`ifdef ALU_ARB_PERF_EN
    logic [31:0] perf_grant0, perf_grant1, perf_stall;
`endif

    typedef struct {
        logic        id;
        logic [31:0] result;
        logic        zero;
        logic        illegal;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32), .OPW(3), .FIXED_PRIO(FIXED_PRIO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal)
`ifdef ALU_ARB_PERF_EN
        , .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_stall(perf_stall)
`endif
    );

    function automatic exp_t model(input logic id, input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op);
        exp_t e;
        e.id = id;
        case (op)
            3'd0:    e.result = a + b;
            3'd1:    e.result = a - b;
            3'd2:    e.result = a & b;
            3'd3:    e.result = a | b;
            3'd4:    e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: e.result = 32'd0;
        endcase
        e.zero    = (e.result == 32'd0);
        e.illegal = (op > 3'd4);
        return e;
    endfunction

    // Called just before a rising edge: retire the visible response, log new transfers.
    task automatic tick();
        exp_t e;
        if (rsp_valid && rsp_ready) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: response id=%0d result=%0d with nothing expected",
                         rsp_id, rsp_result);
            end else begin
                e = sb.pop_front();
                if ({rsp_id, rsp_result, rsp_zero, rsp_illegal} !== {e.id, e.result, e.zero, e.illegal}) begin
                    fails++;
                    $display("FAIL sb_rsp: got id=%0d res=%0d z=%0d ill=%0d, want id=%0d res=%0d z=%0d ill=%0d",
                             rsp_id, rsp_result, rsp_zero, rsp_illegal, e.id, e.result, e.zero, e.illegal);
                end
            end
        end
        tests++;
        if ((req0_ready && req1_ready) || (req0_ready && !req0_valid) || (req1_ready && !req1_valid)) begin
            fails++;
            $display("FAIL ready_rules: v0=%0d r0=%0d v1=%0d r1=%0d", req0_valid, req0_ready,
                     req1_valid, req1_ready);
        end
        if (req0_valid && req0_ready) sb.push_back(model(1'b0, req0_a, req0_b, req0_op));
        if (req1_valid && req1_ready) sb.push_back(model(1'b1, req1_a, req1_b, req1_op));
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        rsp_ready = 1'b1;
        repeat (n) begin
            #2;
            tick();
        end
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req0_valid = 0; req1_valid = 0; rsp_ready = 1;
        req0_a = 0; req0_b = 0; req0_op = 0; req1_a = 0; req1_b = 0; req1_op = 0;
        #2;
        tests++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal} !== 36'd0) begin
            fails++;
            $display("FAIL reset_outputs: got v=%0d id=%0d res=%0d z=%0d ill=%0d, want all 0",
                     rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal);
        end
`ifdef ALU_ARB_PERF_EN
        tests++;
        if ({perf_grant0, perf_grant1, perf_stall} !== 96'd0) begin
            fails++;
            $display("FAIL reset_perf: got %0d %0d %0d, want 0 0 0", perf_grant0, perf_grant1, perf_stall);
        end
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #2;
        tests++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            fails++;
            $display("FAIL idle_ready: got r0=%0d r1=%0d, want 0 0", req0_ready, req1_ready);
        end
        tick();
    endtask

    task automatic test_single();
        rsp_ready = 1; req0_valid = 1; req0_a = 15; req0_b = 10; req0_op = 3'd0;
        #2;
        tests++;
        if (req0_ready !== 1'b1) begin
            fails++; $display("FAIL single_ready: got %0d, want 1", req0_ready);
        end
        tick();
        req0_valid = 0;
        #2;
        tests++;
        if ({rsp_valid, rsp_id, rsp_result, rsp_zero} !== {1'b1, 1'b0, 32'd25, 1'b0}) begin
            fails++;
            $display("FAIL single_rsp: got v=%0d id=%0d res=%0d z=%0d, want 1 0 25 0",
                     rsp_valid, rsp_id, rsp_result, rsp_zero);
        end
        tick();
        #2;
        tests++;
        if (rsp_valid !== 1'b0) begin
            fails++; $display("FAIL single_empty: got rsp_valid=%0d, want 0", rsp_valid);
        end
        tick();
    endtask

    task automatic test_contention();
        apply_reset();
        rsp_ready = 1;
        req0_valid = 1; req0_a = 15; req0_b = 15; req0_op = 3'd1;
        req1_valid = 1; req1_a = -32'sd5; req1_b = 2; req1_op = 3'd4;
        #2;
        tests++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            fails++; $display("FAIL cont_first: got r0=%0d r1=%0d, want 1 0", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 0;
        #2;
        tests++;
        if ({rsp_id, rsp_result, rsp_zero, req1_ready} !== {1'b0, 32'd0, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL cont_rsp0: got id=%0d res=%0d z=%0d r1=%0d, want 0 0 1 1",
                     rsp_id, rsp_result, rsp_zero, req1_ready);
        end
        tick();
        req1_valid = 0;
        #2;
        tests++;
        if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b1, 32'd1}) begin
            fails++;
            $display("FAIL cont_rsp1: got v=%0d id=%0d res=%0d, want 1 1 1", rsp_valid, rsp_id, rsp_result);
        end
        tick();
        drain(1);
    endtask

    task automatic test_round_robin();
        logic exp_id;
        apply_reset();
        rsp_ready = 1;
        req0_valid = 1; req0_a = 1;   req0_b = 2; req0_op = 3'd0;
        req1_valid = 1; req1_a = 100; req1_b = 7; req1_op = 3'd1;
        for (int k = 0; k < 6; k++) begin
            exp_id = (FIXED_PRIO != 0) ? 1'b0 : k[0];
            #2;
            tests++;
            if ({req0_ready, req1_ready} !== {!exp_id, exp_id}) begin
                fails++;
                $display("FAIL rr_grant%0d: got r0=%0d r1=%0d, want port %0d", k, req0_ready, req1_ready, exp_id);
            end
            tick();
            if (exp_id) req1_b = 32'(k + 1);
            else        req0_a = 32'(k + 10);
        end
        req0_valid = 0; req1_valid = 0;
`ifdef ALU_ARB_PERF_EN
        #1;
        tests++;
        if (perf_grant0 !== ((FIXED_PRIO != 0) ? 32'd6 : 32'd3) ||
            perf_grant1 !== ((FIXED_PRIO != 0) ? 32'd0 : 32'd3) || perf_stall !== 32'd6) begin
            fails++;
            $display("FAIL perf_counts: got g0=%0d g1=%0d st=%0d", perf_grant0, perf_grant1, perf_stall);
        end
        @(negedge clk);
`endif
        drain(2);
    endtask

    task automatic test_backpressure();
        rsp_ready = 0;
        req1_valid = 1; req1_a = 12; req1_b = 10; req1_op = 3'd3;
        #2;
        tests++;
        if (req1_ready !== 1'b1) begin
            fails++; $display("FAIL bp_fill: got r1=%0d, want 1", req1_ready);
        end
        tick();
        req1_op = 3'd2;
        for (int c = 0; c < 3; c++) begin
            #2;
            tests++;
            if ({rsp_valid, rsp_result, req0_ready, req1_ready} !== {1'b1, 32'd14, 1'b0, 1'b0}) begin
                fails++;
                $display("FAIL bp_hold%0d: got v=%0d res=%0d r0=%0d r1=%0d, want 1 14 0 0",
                         c, rsp_valid, rsp_result, req0_ready, req1_ready);
            end
            tick();
        end
        rsp_ready = 1;
        #2;
        tests++;
        if (req1_ready !== 1'b1 || rsp_result !== 32'd14) begin
            fails++;
            $display("FAIL bp_release: got r1=%0d res=%0d, want 1 14", req1_ready, rsp_result);
        end
        tick();
        req1_valid = 0;
        #2;
        tests++;
        if (rsp_result !== 32'd8) begin
            fails++; $display("FAIL bp_next: got res=%0d, want 8", rsp_result);
        end
        tick();
        drain(1);
    endtask

    task automatic test_illegal_reset();
        rsp_ready = 0;
        req0_valid = 1; req0_a = 5; req0_b = 3; req0_op = 3'd7;
        #2;
        tick();
        req0_valid = 0;
        #2;
        tests++;
        if (rsp_valid !== 1'b1 || rsp_illegal !== 1'b1 || rsp_zero !== 1'b1) begin
            fails++;
            $display("FAIL illegal_flag: got v=%0d ill=%0d z=%0d, want 1 1 1", rsp_valid, rsp_illegal, rsp_zero);
        end
        rst_n = 0;
        #1;
        tests++;
        if (rsp_valid !== 1'b0 || rsp_illegal !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: got v=%0d ill=%0d, want 0 0", rsp_valid, rsp_illegal);
        end
        sb.delete();
        @(negedge clk);
        rst_n = 1;
        rsp_ready = 1;
        req0_valid = 1; req0_a = 1; req0_b = 1; req0_op = 3'd0;
        req1_valid = 1; req1_a = 2; req1_b = 2; req1_op = 3'd0;
        #2;
        tests++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_last_grant: got r0=%0d r1=%0d, want 1 0", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 0; req1_valid = 0;
        drain(2);
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_round_robin();
        test_backpressure();
        test_illegal_reset();
        tests++;
        if (sb.size() != 0) begin
            fails++; $display("FAIL sb_leftover: %0d responses never delivered, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
